// File: rtl/master_arbiter.sv
// master_arbiter
//   Round-robin bus arbiter. Produces a registered one-hot grant and the binary
//   SEL code for the downstream bus multiplexer. A grant is held until the owner
//   drops its request, followed by one dead turnaround cycle before the next grant.
//   Optional watchdog (build macro ARB_TIMEOUT_EN) revokes an owner that keeps
//   the bus for MAX_HOLD cycles and gives it lowest priority for the next pick.
//
// Ports
//   CLK      in   clock, all state on rising edge
//   RESET_N  in   asynchronous active-low reset
//   REQ      in   per-master request level, held for the whole transfer
//   GNT      out  one-hot grant, all-zero when no owner (registered)
//   SEL      out  index of current/last owner for the multiplexer (registered)
//   BUSY     out  high while a grant is active (|GNT)
//   TIMEOUT  out  one-cycle pulse on watchdog revoke; constant 0 without ARB_TIMEOUT_EN
//
// States
//   ST_IDLE    | no owner, arbitrate on any request
//   ST_GRANT   | owner holds the bus while its request stays high
//   ST_RELEASE | bus turnaround cycle, arbitrate exactly as in idle

module master_arbiter #(
  parameter int NUM_OF_INPUT    = 16,
  parameter int NUM_OF_SEL_BITS = 4,
  parameter int MAX_HOLD        = 255
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [NUM_OF_INPUT-1:0]    REQ,
  output logic [NUM_OF_INPUT-1:0]    GNT,
  output logic [NUM_OF_SEL_BITS-1:0] SEL,
  output logic                       BUSY,
  output logic                       TIMEOUT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [NUM_OF_INPUT-1:0]    r_gnt, w_gnt_nxt;
  logic [NUM_OF_SEL_BITS-1:0] r_sel, w_sel_nxt;
  logic [NUM_OF_SEL_BITS-1:0] r_ptr, w_ptr_nxt;

  logic                       w_any;
  logic [NUM_OF_SEL_BITS-1:0] w_win;
  int                         w_idx;
  logic                       w_new_grant;
  logic                       w_revoke;

  // Search starts one past the last owner and wraps, so the last owner is
  // considered last and still wins when it is the only requester.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 1; k <= NUM_OF_INPUT; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_OF_INPUT) w_idx = w_idx - NUM_OF_INPUT;
      if (!w_any && REQ[NUM_OF_SEL_BITS'(w_idx)]) begin
        w_any = 1'b1;
        w_win = NUM_OF_SEL_BITS'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_any) begin
          w_state_nxt      = ST_GRANT;
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_sel_nxt        = w_win;
          w_ptr_nxt        = w_win;
          w_new_grant      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        // SEL keeps the owner index through release so the mux output is stable.
        if (!REQ[r_ptr] || w_revoke) begin
          w_state_nxt = ST_RELEASE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= NUM_OF_SEL_BITS'(NUM_OF_INPUT - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  logic [15:0] r_hold_cnt;
  logic        r_timeout;

  // Counter holds the number of completed grant cycles; revoke fires on the
  // edge that would make it MAX_HOLD. The pointer is left on the offender.
  assign w_revoke = (r_state == ST_GRANT) && REQ[r_ptr] && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_revoke;
      if (w_new_grant)              r_hold_cnt <= '0;
      else if (r_state == ST_GRANT) r_hold_cnt <= r_hold_cnt + 16'd1;
    end
  end

  assign TIMEOUT = r_timeout;
`else
  logic w_unused;

  assign w_revoke = 1'b0;
  assign TIMEOUT  = 1'b0;
  assign w_unused = w_new_grant | (MAX_HOLD != 0);
`endif

  assign GNT  = r_gnt;
  assign SEL  = r_sel;
  assign BUSY = |r_gnt;

endmodule

// File: tb/tb_master_arbiter.sv
// tb_master_arbiter
//   Scoreboard bench for master_arbiter (16 masters, MAX_HOLD=4). A reference
//   model tracks "current owner / last owner" and pushes every expected grant
//   into a queue; a monitor on the falling edge pops one entry per new grant
//   and also compares GNT/SEL/BUSY/TIMEOUT against the model every cycle.
//   Define ARB_TIMEOUT_EN on both DUT and bench to exercise the watchdog.

module tb_master_arbiter;
  localparam int N  = 16;
  localparam int SB = 4;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [N-1:0]  REQ = '0;
  logic [N-1:0]  GNT;
  logic [SB-1:0] SEL;
  logic          BUSY;
  logic          TIMEOUT;

  int total = 0;
  int bad   = 0;

  master_arbiter #(.NUM_OF_INPUT(N), .NUM_OF_SEL_BITS(SB), .MAX_HOLD(MH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .GNT(GNT),
    .SEL(SEL), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int           m_owner;   // -1 when the bus has no owner
  int           m_last;
  int           m_held;
  int           m_sel;
  bit           m_to;
  logic [N-1:0] m_req;
  int           exp_q[$];
  int           obs[$];

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_owner = -1;
      m_last  = N - 1;
      m_held  = 0;
      m_sel   = 0;
      m_to    = 0;
      m_req   = '0;
      exp_q.delete();
    end else begin
      m_req = REQ;
      m_to  = 0;
      if (m_owner >= 0) begin
        if (!REQ[m_owner]) m_owner = -1;
        else begin
          m_held++;
          if (TO_EN && m_held >= MH) begin
            m_owner = -1;
            m_to    = 1;
          end
        end
      end else if (REQ != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (REQ[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_last = m_owner;
        m_sel  = m_owner;
        m_held = 0;
        exp_q.push_back(m_owner);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] prev_gnt = '0;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      prev_gnt = '0;
    end else begin
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk(GNT == eg, "gnt", 32'(GNT), 32'(eg));
      chk(32'(SEL) == 32'(m_sel), "sel", 32'(SEL), 32'(m_sel));
      chk(BUSY == (m_owner >= 0), "busy", 32'(BUSY), 32'(m_owner >= 0));
      chk(TIMEOUT == m_to, "timeout", 32'(TIMEOUT), 32'(m_to));
      chk($onehot0(GNT), "onehot0", 32'(GNT), 0);
      chk((GNT & ~m_req) == '0, "gnt_no_req", 32'(GNT), 32'(m_req));
      if (BUSY) chk(32'(SEL) == 32'(oh_idx(GNT)), "sel_idx", 32'(SEL), 32'(oh_idx(GNT)));
      if (GNT != '0 && GNT != prev_gnt) begin
        obs.push_back(oh_idx(GNT));
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_grant", 32'(GNT), 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk(oh_idx(GNT) == e, "sb_grant", 32'(oh_idx(GNT)), 32'(e));
          chk(32'(SEL) == 32'(e), "sb_sel", 32'(SEL), 32'(e));
        end
      end
      prev_gnt = GNT;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ     = '0;
    RESET_N = 1'b0;
    #3;
    chk(GNT == '0, "rst_gnt", 32'(GNT), 0);
    chk(SEL == '0, "rst_sel", 32'(SEL), 0);
    chk(BUSY == 1'b0, "rst_busy", 32'(BUSY), 0);
    chk(TIMEOUT == 1'b0, "rst_timeout", 32'(TIMEOUT), 0);
    #10;
    RESET_N = 1'b1;
    obs.delete();
    step(1);
  endtask

  // Each master raises REQ, holds it hold_len granted cycles, drops, waits, re-raises.
  task automatic run_auto(input int ncyc, input bit rnd);
    int hold_cnt[N];
    int hold_len[N];
    int off_cnt[N];
    logic [N-1:0] r;
    r = REQ;
    for (int i = 0; i < N; i++) begin
      hold_cnt[i] = 0;
      off_cnt[i]  = 0;
      hold_len[i] = rnd ? int'($urandom_range(1, 7)) : 2;
    end
    repeat (ncyc) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (GNT[i]) begin
            hold_cnt[i]++;
            if (hold_cnt[i] >= hold_len[i]) begin
              r[i]        = 1'b0;
              hold_cnt[i] = 0;
              off_cnt[i]  = rnd ? int'($urandom_range(0, 5)) : 3;
              if (rnd) hold_len[i] = int'($urandom_range(1, 7));
            end
          end
        end else if (off_cnt[i] > 0) begin
          off_cnt[i]--;
        end else if (!rnd || $urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
        end
      end
      REQ = r;
    end
  endtask

  initial begin
    int held;
    int to_seen;

    // 1: single master, latency and release
    do_reset();
    REQ = 16'h0001;
    step(1);
    chk(GNT == 16'h0001, "t1_gnt", 32'(GNT), 1);
    chk(SEL == 4'd0, "t1_sel", 32'(SEL), 0);
    chk(BUSY == 1'b1, "t1_busy", 32'(BUSY), 1);
    REQ = '0;
    step(1);
    chk(GNT == '0, "t1_gnt_drop", 32'(GNT), 0);
    chk(SEL == 4'd0, "t1_sel_hold", 32'(SEL), 0);

    // 2: everyone requesting, grants rotate 0..15,0
    do_reset();
    REQ = 16'hFFFF;
    run_auto(70, 1'b0);
    chk(obs.size() >= 17, "t2_count", 32'(obs.size()), 17);
    for (int k = 0; k < 17; k++)
      if (k < obs.size()) chk(obs[k] == k % N, "t2_order", 32'(obs[k]), 32'(k % N));
    REQ = '0;
    step(4);

    // 3: owner 5, then 9 and 3 in wrap order
    do_reset();
    REQ = 16'h0020;
    step(2);
    REQ = 16'h0228;
    step(2);
    REQ = 16'h0208;
    step(2);
    chk(GNT == 16'h0200, "t3_gnt9", 32'(GNT), 32'h200);
    chk(SEL == 4'd9, "t3_sel9", 32'(SEL), 9);
    step(1);
    REQ = 16'h0008;
    step(2);
    chk(GNT == 16'h0008, "t3_gnt3", 32'(GNT), 32'h8);
    chk(SEL == 4'd3, "t3_sel3", 32'(SEL), 3);
    REQ = '0;
    step(3);
    chk(SEL == 4'd3, "t3_sel_idle", 32'(SEL), 3);
    chk(obs.size() == 3, "t3_count", 32'(obs.size()), 3);
    if (obs.size() == 3) begin
      chk(obs[0] == 5, "t3_o0", 32'(obs[0]), 5);
      chk(obs[1] == 9, "t3_o1", 32'(obs[1]), 9);
      chk(obs[2] == 3, "t3_o2", 32'(obs[2]), 3);
    end

    // 4: asynchronous reset mid-grant
    do_reset();
    REQ = 16'h0080;
    step(2);
    chk(GNT == 16'h0080, "t4_gnt7", 32'(GNT), 32'h80);
    #3;
    RESET_N = 1'b0;
    #1;
    chk(GNT == '0, "t4_rst_gnt", 32'(GNT), 0);
    chk(SEL == '0, "t4_rst_sel", 32'(SEL), 0);
    chk(BUSY == 1'b0, "t4_rst_busy", 32'(BUSY), 0);
    #2;
    RESET_N = 1'b1;
    REQ = 16'h0081;
    step(1);
    chk(GNT == 16'h0001, "t4_gnt0", 32'(GNT), 1);
    REQ = '0;
    step(3);

    // 5: stuck owner 2 with master 6 waiting
    do_reset();
    REQ = 16'h0004;
    step(1);
    chk(GNT == 16'h0004, "t5_gnt2", 32'(GNT), 4);
    REQ = 16'h0044;
`ifdef ARB_TIMEOUT_EN
    step(3);
    chk(GNT == 16'h0004, "t5_still2", 32'(GNT), 4);
    step(1);
    chk(GNT == '0, "t5_revoke", 32'(GNT), 0);
    chk(TIMEOUT == 1'b1, "t5_to_pulse", 32'(TIMEOUT), 1);
    step(1);
    chk(GNT == 16'h0040, "t5_gnt6", 32'(GNT), 32'h40);
    chk(TIMEOUT == 1'b0, "t5_to_low", 32'(TIMEOUT), 0);
`else
    held    = 0;
    to_seen = 0;
    repeat (100) begin
      step(1);
      if (GNT == 16'h0004) held++;
      if (TIMEOUT) to_seen++;
    end
    chk(held == 100, "t5_hold", 32'(held), 100);
    chk(to_seen == 0, "t5_no_to", 32'(to_seen), 0);
`endif
    REQ = '0;
    step(8);

    // random traffic against the model
    do_reset();
    run_auto(3000, 1'b1);
    REQ = '0;
    step(20);
    chk(exp_q.size() == 0, "sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
